// File: rtl/graph_lut_stream_fp16.sv
// -----------------------------------------------------------------------------
// graph_lut_stream_fp16
//
// Command-driven streaming initiator for a 256-entry FP16 unary LUT ROM.
// The block reads an FP16 vector from scratch SRAM and uses the upper byte of
// each word as the LUT address. It then writes the registered LUT result back
// to SRAM. Throughput is one element per cycle, with no backpressure anywhere.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake from the graph sequencer
//   cmd_src/dst/len       first source word, first destination word, count
//   rd_en/rd_addr/rd_data SRAM read port (data returns the cycle after rd_en)
//   lut_addr/lut_data     LUT ROM port (data returns the cycle after address)
//   wr_en/wr_addr/wr_data SRAM write port
//   busy                  high from the first RUN cycle through the DONE cycle
//   done                  one-cycle pulse when the job is complete
//   nan_count             NaN results written by the last job, saturating
//   dbg_state             current FSM state, for observation only
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready
// are both high. The requester keeps cmd_src/dst/len stable while cmd_valid is
// high. cmd_ready is high only in IDLE. It does not depend combinationally on
// cmd_valid. cmd_valid is ignored while the block is busy.
// -----------------------------------------------------------------------------
module graph_lut_stream_fp16 #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic [7:0]        lut_addr,
  input  logic [15:0]       lut_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  nan_count,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;      // reads still to issue
  logic              rd_vld_q, rd_vld_d; // rd_data / lut_addr valid this cycle
  logic              wr_en_q, wr_en_d;   // lut_data valid this cycle
  logic [CNT_W-1:0]  nan_q, nan_d;
  logic              wr_is_nan;

  // Only the upper byte of the word addresses the LUT.
  logic unused_rd_low;
  assign unused_rd_low = ^rd_data[7:0];

  // An FP16 NaN has an all-ones exponent and a nonzero mantissa.
  assign wr_is_nan = (lut_data[14:10] == 5'h1F) && (lut_data[9:0] != 10'd0);

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    rem_d     = rem_q;
    nan_d     = nan_q;
    // Two-stage valid pipe: SRAM read latency, then LUT latency.
    rd_vld_d  = (state_q == S_RUN);
    wr_en_d   = rd_vld_q;

    // Write side runs independently of the FSM. It drains during DRAIN.
    if (wr_en_q) begin
      wr_addr_d = wr_addr_q + ADDR_ONE;
      if (wr_is_nan && (nan_q != CNT_MAX)) begin
        nan_d = nan_q + CNT_ONE;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          rd_addr_d = cmd_src;
          wr_addr_d = cmd_dst;
          rem_d     = cmd_len;
          nan_d     = '0;
          state_d   = (cmd_len == LEN_ZERO) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        rd_addr_d = rd_addr_q + ADDR_ONE;
        rem_d     = rem_q - LEN_ONE;
        if (rem_q == LEN_ONE) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Once the read stage is empty, the write in flight now is the last.
        if (!rd_vld_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rem_q     <= '0;
      rd_vld_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      nan_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      rem_q     <= rem_d;
      rd_vld_q  <= rd_vld_d;
      wr_en_q   <= wr_en_d;
      nan_q     <= nan_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rd_en     = (state_q == S_RUN);
  assign rd_addr   = rd_addr_q;
  assign lut_addr  = rd_data[15:8];
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = lut_data;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign nan_count = nan_q;
  assign dbg_state = state_q;

endmodule
